loop_sequencer: RTL and testbench

//  Two-level (row/column) loop scheduler for the downsampling datapath.

---
 rtl/loop_sequencer_if.sv | 37 +++
 rtl/loop_sequencer.sv | 119 +++++++++++
 tb/tb_loop_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/loop_sequencer_if.sv
// Handshake and loop-register bundle between the loop sequencer
// and the downsampling datapath / loop register.
interface loop_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] outer_count;
    logic [WIDTH-1:0] inner_count;
    logic             lrz_flag;
    logic             body_done;
    logic             lr_we;
    logic             lr_decrement;
    logic [WIDTH-1:0] lr_load_value;
    logic             body_start;
    logic             row_end;
    logic [WIDTH-1:0] row_idx;
    logic [WIDTH-1:0] col_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, outer_count, inner_count,
        input  lrz_flag, body_done,
        output lr_we, lr_decrement, lr_load_value,
        output body_start, row_end, row_idx, col_idx,
        output busy, done
    );

    modport slave (
        output start, abort, outer_count, inner_count,
        output lrz_flag, body_done,
        input  lr_we, lr_decrement, lr_load_value,
        input  body_start, row_end, row_idx, col_idx,
        input  busy, done
    );
endinterface

// File: rtl/loop_sequencer.sv
// Row/column loop scheduler driving the shared loop register and
// the per-pixel body_start/body_done handshake.
module loop_sequencer #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    loop_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DEC,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] outer_lat;
    logic [WIDTH-1:0] inner_lat;

    // Every output is a register loaded with its value for the
    // state being entered, so nothing is combinational from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            outer_lat         <= '0;
            inner_lat         <= '0;
            bus.lr_we         <= 1'b0;
            bus.lr_decrement  <= 1'b0;
            bus.lr_load_value <= '0;
            bus.body_start    <= 1'b0;
            bus.row_end       <= 1'b0;
            bus.row_idx       <= '0;
            bus.col_idx       <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            bus.lr_we        <= 1'b0;
            bus.lr_decrement <= 1'b0;
            bus.body_start   <= 1'b0;
            bus.row_end      <= 1'b0;
            bus.done         <= 1'b0;
            if (bus.abort && state != S_IDLE) begin
                state       <= S_IDLE;
                bus.busy    <= 1'b0;
                bus.row_idx <= '0;
                bus.col_idx <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            outer_lat         <= bus.outer_count;
                            inner_lat         <= bus.inner_count;
                            bus.lr_load_value <= bus.inner_count;
                            bus.busy          <= 1'b1;
                            if (bus.outer_count == '0 ||
                                bus.inner_count == '0) begin
                                state    <= S_DONE;
                                bus.done <= 1'b1;
                            end else begin
                                state       <= S_LOAD;
                                bus.lr_we   <= 1'b1;
                                bus.col_idx <= '0;
                            end
                        end
                    end
                    S_LOAD: begin
                        state          <= S_ISSUE;
                        bus.body_start <= 1'b1;
                    end
                    S_ISSUE: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.body_done) begin
                            state            <= S_DEC;
                            bus.lr_decrement <= 1'b1;
                        end
                    end
                    S_DEC: begin
                        state       <= S_CHECK;
                        bus.col_idx <= bus.col_idx + 1'b1;
                        // Last column of a non-final row is known here.
                        bus.row_end <=
                            (bus.col_idx + 1'b1 == inner_lat) &&
                            (bus.row_idx != outer_lat - 1'b1);
                    end
                    S_CHECK: begin
                        if (!bus.lrz_flag) begin
                            state          <= S_ISSUE;
                            bus.body_start <= 1'b1;
                        end else if (bus.row_idx == outer_lat - 1'b1) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= S_LOAD;
                            bus.lr_we   <= 1'b1;
                            bus.row_idx <= bus.row_idx + 1'b1;
                            bus.col_idx <= '0;
                        end
                    end
                    S_DONE: begin
                        state       <= S_IDLE;
                        bus.busy    <= 1'b0;
                        bus.row_idx <= '0;
                        bus.col_idx <= '0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with a behavioural loop
// register and hand-computed pulse timings.
module tb_loop_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    loop_sequencer_if #(.WIDTH(16)) bus ();

    loop_sequencer #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [15:0] lr = '0;
    assign bus.lrz_flag = (lr == 16'd0);
    always @(posedge clk) begin
        if (bus.lr_we) lr <= bus.lr_load_value;
        else if (bus.lr_decrement) lr <= lr - 16'd1;
    end

    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int bs_q[$];
    int idx_q[$];
    int re_q[$];
    int done_q[$];
    int we_q[$];
    int dec_n = 0;
    int both_n = 0;
    int busy_lo = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.body_start) begin
                bs_q.push_back(cyc - base);
                idx_q.push_back(int'(bus.row_idx) * 256 + int'(bus.col_idx));
            end
            if (bus.row_end) re_q.push_back(cyc - base);
            if (bus.done) done_q.push_back(cyc - base);
            if (bus.lr_we) we_q.push_back(cyc - base);
            if (bus.lr_decrement) dec_n++;
            if (bus.lr_we && bus.lr_decrement) both_n++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic go(input int o, input int i, input logic ab);
        @(negedge clk);
        bs_q.delete(); idx_q.delete(); re_q.delete();
        done_q.delete(); we_q.delete();
        dec_n = 0; both_n = 0; busy_lo = 0;
        bus.outer_count = 16'(o);
        bus.inner_count = 16'(i);
        bus.start = 1'b1;
        bus.abort = ab;
        base = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done_q.size() == 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done_q.size() > 0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rel(input int k);
        int n = 0;
        while ((cyc - base) != k && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_cycle", cyc - base, k);
    endtask

    task automatic run_2x3(input string t);
        int ebs[6] = '{2, 6, 10, 15, 19, 23};
        int eix[6] = '{0, 1, 2, 256, 257, 258};
        bus.body_done = 1'b1;
        go(2, 3, 1'b0);
        wait_done(60);
        check({t, "_bs_n"}, bs_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check({t, "_bs_cyc"}, at(bs_q, k), ebs[k]);
            check({t, "_idx"}, at(idx_q, k), eix[k]);
        end
        check({t, "_re_n"}, re_q.size(), 1);
        check({t, "_re_cyc"}, at(re_q, 0), 13);
        check({t, "_done_n"}, done_q.size(), 1);
        check({t, "_done_cyc"}, at(done_q, 0), 27);
        check({t, "_we_n"}, we_q.size(), 2);
        check({t, "_we0"}, at(we_q, 0), 1);
        check({t, "_we1"}, at(we_q, 1), 14);
        check({t, "_dec_n"}, dec_n, 6);
        check({t, "_we_dec"}, both_n, 0);
        check({t, "_busy_end"}, int'(bus.busy), 0);
        check({t, "_row_end"}, int'(bus.row_idx), 0);
    endtask

    int bd_tab[13] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    int st_tab[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.outer_count = '0;
        bus.inner_count = '0;
        bus.body_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_we", int'(bus.lr_we), 0);
        check("rst_bs", int'(bus.body_start), 0);
        check("rst_row", int'(bus.row_idx), 0);
        check("rst_col", int'(bus.col_idx), 0);
        check("rst_lv", int'(bus.lr_load_value), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two rows of three pixels, body_done tied high
        run_2x3("t1");

        // single pixel, body_done 5 cycles after body_start
        bus.body_done = 1'b0;
        go(1, 1, 1'b0);
        wait_rel(2);
        check("t2_bs", int'(bus.body_start), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.busy) busy_lo++;
        end
        bus.body_done = 1'b1;
        @(negedge clk);
        bus.body_done = 1'b0;
        wait_done(30);
        check("t2_busy_wait", busy_lo, 0);
        check("t2_dec_n", dec_n, 1);
        check("t2_done_n", done_q.size(), 1);
        check("t2_done_cyc", at(done_q, 0), 10);
        check("t2_re_n", re_q.size(), 0);

        // zero counts finish immediately
        go(5, 0, 1'b0);
        wait_done(10);
        check("t3a_done_cyc", at(done_q, 0), 1);
        check("t3a_we_n", we_q.size(), 0);
        check("t3a_bs_n", bs_q.size(), 0);
        go(0, 5, 1'b0);
        wait_done(10);
        check("t3b_done_cyc", at(done_q, 0), 1);
        check("t3b_we_n", we_q.size(), 0);
        check("t3b_bs_n", bs_q.size(), 0);

        // abort in WAIT of the second pixel
        bus.body_done = 1'b1;
        go(3, 4, 1'b0);
        wait_rel(7);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("t4_busy", int'(bus.busy), 0);
        check("t4_row", int'(bus.row_idx), 0);
        check("t4_col", int'(bus.col_idx), 0);
        repeat (6) @(negedge clk);
        check("t4_bs_n", bs_q.size(), 2);
        check("t4_done_n", done_q.size(), 0);
        check("t4_dec_n", dec_n, 1);
        go(1, 2, 1'b1);
        wait_done(30);
        check("t4r_bs_n", bs_q.size(), 2);
        check("t4r_bs1", at(bs_q, 1), 6);
        check("t4r_done_cyc", at(done_q, 0), 10);

        // stray start and body_done outside WAIT
        bus.body_done = 1'b0;
        go(1, 2, 1'b0);
        for (int k = 1; k < 13; k++) begin
            @(negedge clk);
            bus.body_done = bd_tab[cyc - base] != 0;
            bus.start = st_tab[cyc - base] != 0;
        end
        bus.body_done = 1'b0;
        bus.start = 1'b0;
        wait_done(20);
        check("t5_bs_n", bs_q.size(), 2);
        check("t5_bs0", at(bs_q, 0), 2);
        check("t5_bs1", at(bs_q, 1), 7);
        check("t5_dec_n", dec_n, 2);
        check("t5_done_n", done_q.size(), 1);
        check("t5_done_cyc", at(done_q, 0), 12);

        // async reset during DEC, then a clean run
        bus.body_done = 1'b1;
        go(2, 3, 1'b0);
        wait_rel(4);
        check("t6_in_dec", int'(bus.lr_decrement), 1);
        rst = 1'b1;
        #1;
        check("t6_busy", int'(bus.busy), 0);
        check("t6_dec", int'(bus.lr_decrement), 0);
        check("t6_col", int'(bus.col_idx), 0);
        check("t6_lv", int'(bus.lr_load_value), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_2x3("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
